// File: rtl/teller_dispatch_pkg.sv
// Shared queue package: FSM state encoding, teller-count width and
// round-robin helpers used by the teller dispatcher.
package teller_dispatch_pkg;

    localparam int NUM_TELLERS = 3;
    localparam int TCOUNT_W    = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALL = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // Tellers 1..tcount are eligible; bit i stands for teller i+1.
    function automatic logic [NUM_TELLERS-1:0] eligible_mask(input logic [TCOUNT_W-1:0] tcount);
        case (tcount)
            2'd1:    eligible_mask = 3'b001;
            2'd2:    eligible_mask = 3'b011;
            2'd3:    eligible_mask = 3'b111;
            default: eligible_mask = 3'b000;
        endcase
    endfunction

    // Returns the first available teller after 'last' (wrapping 3 -> 1), 0 if none.
    function automatic logic [TCOUNT_W-1:0] rr_pick(input logic [TCOUNT_W-1:0] last,
                                                    input logic [NUM_TELLERS-1:0] avail);
        logic [TCOUNT_W-1:0] cand;
        rr_pick = 2'd0;
        cand    = last;
        for (int k = 0; k < NUM_TELLERS; k++) begin
            cand = (cand == 2'd3) ? 2'd1 : cand + 2'd1;
            if (rr_pick == 2'd0 && avail[cand - 2'd1]) begin
                rr_pick = cand;
            end
        end
    endfunction

endpackage

// File: rtl/sevenSegments.sv
// Seven-segment decoder, segments {g,f,e,d,c,b,a}, active high.
// Purely combinational.
module sevenSegments (
    input  logic [3:0] digit,
    output logic [6:0] seg
);
    always_comb begin
        case (digit)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
    end
endmodule

// File: rtl/teller_dispatch.sv
// Calls the next free eligible teller round-robin, pulses down for one cycle, then holds the display.
// Optional per-teller service timeout when SERVICE_TIMEOUT_EN is defined.
module teller_dispatch
    import teller_dispatch_pkg::*;
#(
    parameter int HOLD_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [TCOUNT_W-1:0]    Tcount,
    input  logic                   empty_flag,
    input  logic [NUM_TELLERS-1:0] teller_done,
    output logic                   down,
    output logic [NUM_TELLERS-1:0] busy,
    output logic [TCOUNT_W-1:0]    call_teller,
    output logic [7:0]             served,
    output logic [6:0]             leds_call
);
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    state_e                 state_q, state_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic [NUM_TELLERS-1:0] busy_q, busy_d;
    logic [TCOUNT_W-1:0]    call_q, call_d;
    logic [TCOUNT_W-1:0]    ptr_q, ptr_d;
    logic [7:0]             served_q, served_d;

    logic [NUM_TELLERS-1:0] timeout_hit, release_mask, busy_left, avail, call_mask;
    logic [TCOUNT_W-1:0]    pick;

    // Releases are applied before selection so a teller freed on this edge can be re-called on it.
    assign release_mask = teller_done | timeout_hit;
    assign busy_left    = busy_q & ~release_mask;
    assign avail        = eligible_mask(Tcount) & ~busy_left;
    assign pick         = rr_pick(ptr_q, avail);

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        busy_d    = busy_left;
        call_d    = call_q;
        ptr_d     = ptr_q;
        served_d  = served_q;
        call_mask = '0;
        case (state_q)
            ST_IDLE: begin
                if (!empty_flag && pick != 2'd0) begin
                    call_mask = 3'b001 << (pick - 2'd1);
                    state_d   = ST_CALL;
                    busy_d    = busy_left | call_mask;
                    call_d    = pick;
                    ptr_d     = pick;
                    if (served_q != 8'hFF) begin
                        served_d = served_q + 8'd1;
                    end
                end
            end
            ST_CALL: begin
                state_d = ST_HOLD;
                hold_d  = '0;
            end
            ST_HOLD: begin
                if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            hold_q   <= '0;
            busy_q   <= '0;
            call_q   <= '0;
            ptr_q    <= 2'd3;
            served_q <= '0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            busy_q   <= busy_d;
            call_q   <= call_d;
            ptr_q    <= ptr_d;
            served_q <= served_d;
        end
    end

`ifdef SERVICE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] age_q [NUM_TELLERS];
    logic [TO_W-1:0] age_d [NUM_TELLERS];

    always_comb begin
        timeout_hit = '0;
        for (int i = 0; i < NUM_TELLERS; i++) begin
            timeout_hit[i] = busy_q[i] && (age_q[i] == TO_W'(TIMEOUT_CYCLES - 1));
        end
    end

    // Age restarts on every call so a re-called teller gets a full service window.
    always_comb begin
        for (int i = 0; i < NUM_TELLERS; i++) begin
            age_d[i] = '0;
            if (!call_mask[i] && busy_q[i] && !timeout_hit[i]) begin
                age_d[i] = age_q[i] + TO_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_TELLERS; i++) begin
            if (!reset) begin
                age_q[i] <= '0;
            end else begin
                age_q[i] <= age_d[i];
            end
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout_hit = '0;
`endif

    assign down        = (state_q == ST_CALL);
    assign busy        = busy_q;
    assign call_teller = call_q;
    assign served      = served_q;

    sevenSegments u_seg (
        .digit ({2'b00, call_q}),
        .seg   (leds_call)
    );

endmodule

// File: tb/tb_teller_dispatch.sv
// Bench for teller_dispatch: fixed vector table, hand corner sequences, then random traffic
// against a queue-level reference model.
module tb_teller_dispatch;
    localparam int HOLD = 4;
    localparam int TO   = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] Tcount = 2'd0;
    logic       empty_flag = 1'b1;
    logic [2:0] teller_done = 3'b000;
    logic       down;
    logic [2:0] busy;
    logic [1:0] call_teller;
    logic [7:0] served;
    logic [6:0] leds_call;

    teller_dispatch #(.HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .Tcount      (Tcount),
        .empty_flag  (empty_flag),
        .teller_done (teller_done),
        .down        (down),
        .busy        (busy),
        .call_teller (call_teller),
        .served      (served),
        .leds_call   (leds_call)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: who is serving, whose turn it is, and where the dispatcher is in its call cycle.
    bit m_busy [3];
    int m_call_edge [3];
    int m_last, m_served, m_call, m_phase, m_hold_left, edge_no;

    function automatic logic [6:0] seg_of(input int n);
        case (n)
            0:       return 7'h3F;
            1:       return 7'h06;
            2:       return 7'h5B;
            3:       return 7'h4F;
            default: return 7'h00;
        endcase
    endfunction

    function void m_step(input bit rst, input int tc, input bit emp, input logic [2:0] dn);
        bit found;
        edge_no++;
        if (!rst) begin
            for (int t = 0; t < 3; t++) m_busy[t] = 0;
            m_last = 3; m_served = 0; m_call = 0; m_phase = 0; m_hold_left = 0;
            return;
        end
        for (int t = 0; t < 3; t++) begin
            if (dn[t]) m_busy[t] = 0;
`ifdef SERVICE_TIMEOUT_EN
            if (m_busy[t] && (edge_no - m_call_edge[t] == TO)) m_busy[t] = 0;
`endif
        end
        if (m_phase == 0) begin
            found = 0;
            if (!emp) begin
                for (int k = 1; k <= 3; k++) begin
                    int t;
                    t = (m_last + k - 1) % 3 + 1;
                    if (!found && t <= tc && !m_busy[t-1]) begin
                        found = 1;
                        m_busy[t-1] = 1;
                        m_call_edge[t-1] = edge_no;
                        m_call = t;
                        m_last = t;
                        m_served = (m_served < 255) ? m_served + 1 : 255;
                        m_phase = 1;
                    end
                end
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
            m_hold_left = HOLD;
        end else begin
            m_hold_left--;
            if (m_hold_left == 0) m_phase = 0;
        end
    endfunction

    task automatic cycle(input bit rst, input int tc, input bit emp, input logic [2:0] dn);
        logic [31:0] tcv;
        tcv = tc;
        @(negedge clk);
        reset = rst; Tcount = tcv[1:0]; empty_flag = emp; teller_done = dn;
        @(posedge clk);
        m_step(rst, tc, emp, dn);
        #1;
    endtask

    task automatic check(input string nm, input bit e_down, input logic [2:0] e_busy,
                         input logic [1:0] e_call, input logic [7:0] e_served);
        n_vec++;
        if (down !== e_down || busy !== e_busy || call_teller !== e_call ||
            served !== e_served || leds_call !== seg_of(int'(e_call))) begin
            n_err++;
            $display("FAIL %s: got down=%b busy=%b call=%0d served=%0d leds=%h, expected down=%b busy=%b call=%0d served=%0d leds=%h",
                     nm, down, busy, call_teller, served, leds_call,
                     e_down, e_busy, e_call, e_served, seg_of(int'(e_call)));
        end
    endtask

    task automatic check_model(input string nm);
        check(nm, m_phase == 1, {m_busy[2], m_busy[1], m_busy[0]}, 2'(m_call), 8'(m_served));
    endtask

    task automatic check_val(input string nm, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, got, want);
        end
    endtask

    typedef struct {
        bit         rst;
        int         tc;
        bit         emp;
        logic [2:0] dn;
        bit         e_down;
        logic [2:0] e_busy;
        logic [1:0] e_call;
        logic [7:0] e_served;
    } vec_t;

    vec_t vt [26];
    int   saw_down;

    initial begin
        vt[0]  = '{0, 2, 0, 3'b000, 0, 3'b000, 2'd0, 8'd0};
        vt[1]  = '{1, 2, 0, 3'b000, 1, 3'b001, 2'd1, 8'd1};
        for (int i = 2; i <= 6; i++) vt[i] = '{1, 2, 0, 3'b000, 0, 3'b001, 2'd1, 8'd1};
        vt[7]  = '{1, 2, 0, 3'b000, 1, 3'b011, 2'd2, 8'd2};
        vt[8]  = '{1, 2, 0, 3'b010, 0, 3'b001, 2'd2, 8'd2};
        for (int i = 9; i <= 12; i++) vt[i] = '{1, 2, 0, 3'b000, 0, 3'b001, 2'd2, 8'd2};
        vt[13] = '{1, 2, 0, 3'b000, 1, 3'b011, 2'd2, 8'd3};
        for (int i = 14; i <= 18; i++) vt[i] = '{1, 3, 0, 3'b000, 0, 3'b011, 2'd2, 8'd3};
        vt[19] = '{1, 3, 0, 3'b000, 1, 3'b111, 2'd3, 8'd4};
        for (int i = 20; i <= 24; i++) vt[i] = '{1, 3, 0, 3'b000, 0, 3'b111, 2'd3, 8'd4};
        vt[25] = '{1, 3, 0, 3'b100, 1, 3'b111, 2'd3, 8'd5};

        edge_no = 0;
        for (int i = 0; i < 26; i++) begin
            cycle(vt[i].rst, vt[i].tc, vt[i].emp, vt[i].dn);
`ifdef SERVICE_TIMEOUT_EN
            check_model($sformatf("table_%0d", i));
`else
            check($sformatf("table_%0d", i), vt[i].e_down, vt[i].e_busy, vt[i].e_call, vt[i].e_served);
`endif
        end

        // No calls with zero tellers or an empty queue.
        cycle(0, 0, 0, 3'b000);
        saw_down = 0;
        for (int i = 0; i < 50; i++) begin
            cycle(1, 0, 0, 3'b000);
            saw_down |= int'(down);
        end
        for (int i = 0; i < 50; i++) begin
            cycle(1, 3, 1, 3'b000);
            saw_down |= int'(down);
        end
        check_val("no_call_down", saw_down, 0);
        check_val("no_call_served", int'(served), 0);

        // Reset during CALL and during HOLD.
        cycle(1, 1, 0, 3'b000);
        check("call_before_rst", 1, 3'b001, 2'd1, 8'd1);
        cycle(0, 1, 0, 3'b000);
        check("rst_in_call", 0, 3'b000, 2'd0, 8'd0);
        cycle(1, 1, 1, 3'b000);
        check("after_rst_call", 0, 3'b000, 2'd0, 8'd0);
        cycle(1, 1, 0, 3'b000);
        cycle(1, 1, 1, 3'b000);
        cycle(1, 1, 1, 3'b000);
        check_model("in_hold");
        cycle(0, 1, 1, 3'b000);
        check("rst_in_hold", 0, 3'b000, 2'd0, 8'd0);
        cycle(1, 1, 1, 3'b000);
        check("after_rst_hold", 0, 3'b000, 2'd0, 8'd0);

        // Lowering Tcount: teller 3 finishes and is never called again.
        cycle(0, 3, 0, 3'b000);
        for (int i = 0; i < 20; i++) cycle(1, 3, 0, 3'b000);
        check_model("three_called");
        cycle(1, 1, 0, 3'b100);
        for (int i = 0; i < 20; i++) begin
            cycle(1, 1, 0, 3'b000);
            check_model("tc_lowered");
        end
`ifndef SERVICE_TIMEOUT_EN
        check_val("tc_lowered_busy", int'(busy), 3);
`endif

        // Counter saturation, teller 1 finishing every cycle.
        cycle(0, 1, 0, 3'b000);
        for (int i = 0; i < 1600; i++) begin
            cycle(1, 1, 0, 3'b001);
            check_model("saturate");
        end
        check_val("served_sat", int'(served), 255);

        // No done pulse: busy held unless the timeout is built in.
        cycle(0, 1, 0, 3'b000);
        cycle(1, 1, 0, 3'b000);
        for (int i = 0; i < 30; i++) begin
            cycle(1, 1, 1, 3'b000);
            check_model("timeout");
        end
`ifdef SERVICE_TIMEOUT_EN
        check_val("timeout_busy", int'(busy), 0);
`else
        check_val("timeout_busy", int'(busy), 1);
`endif

        // Random traffic.
        cycle(0, 3, 1, 3'b000);
        for (int i = 0; i < 3000; i++) begin
            bit         r;
            int         tc;
            bit         emp;
            logic [2:0] dn;
            r   = ($urandom_range(0, 199) != 0);
            tc  = $urandom_range(0, 3);
            emp = ($urandom_range(0, 3) == 0);
            dn  = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000;
            cycle(r, tc, emp, dn);
            check_model("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
